intr_req_ctrl: RTL and testbench
================================

// Module: intr_req_ctrl
// PURPOSE
//  Interrupt request front end for the 8-source interrupt path. Synchronises
//  eight raw request lines and latches them as pending bits. Applies a mask
//  register and drives the masked vector into the 8-to-3 priority encoder
//  placed directly downstream. Raises a single CPU interrupt request gated by
//  IEN, then consumes the encoder's 3-bit code on acknowledge to retire that
//  source. Acknowledge also clears IEN, matching the R-cycle of the basic
//  computer.
// PARAMETERS
//  N       8   number of request sources (encoder width; fixed at 8 here)
//  CODE_W  3   width of the encoder code, log2(N)
//  EDGE    1   1 = rising-edge-triggered pending bits, 0 = level-triggered
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_n       in   1       asynchronous reset, active low
//  irq_in      in   N       raw request lines, asynchronous to clk
//  mask_we     in   1       write enable for mask register
//  mask_wdata  in   N       mask data, 1 = source blocked
//  ien_set     in   1       set interrupt enable flag (ION)
//  ien_clr     in   1       clear interrupt enable flag (IOF)
//  ack         in   1       one-cycle CPU acknowledge of int_req
//  enc_code    in   CODE_W  code returned by the downstream priority encoder
//  req_vec     out  N       pend_q & ~mask_q, drives encoder d_in (combinational)
//  int_req     out  1       registered interrupt request to CPU
//  vec_q       out  CODE_W  code captured at last accepted ack
//  pend_q      out  N       pending bits (status)
//  mask_q      out  N       mask register (status)
//  ien_q       out  1       interrupt enable flag
// BEHAVIOUR
//  Reset: while rst_n=0, every flop is 0 (sync, pend, mask, ien, int_req,
//   vec_q, state). Consequently req_vec=0.
//  Sync: 2-flop synchroniser per line (s1, s2). A third flop s3 holds the
//   previous s2 for edge detection.
//  EDGE=1: pend[i] sets on the edge where s2[i]=1 and s3[i]=0. irq_in is
//   sampled high at edge k, so pend_q[i] is visible after edge k+2.
//  EDGE=0: pend[i] sets on every edge where s2[i]=1.
//  Pending bits clear only through an accepted ack, on bit enc_code. If a
//   set and that clear hit the same bit on the same edge, set wins; the
//   new event is not lost.
//  Mask: mask_q <= mask_wdata when mask_we=1. Masking never clears pend,
//   it only hides the bit from req_vec.
//  IEN: ien_clr beats ien_set. An accepted ack clears IEN and beats
//   ien_set in the same cycle.
//  FSM, 2 states, int_req = (state==REQ):
//   IDLE -> REQ  when ien_q=1 and |req_vec=1. int_req is high one edge
//    after the condition is true.
//   REQ  -> IDLE on ack=1 (accepted). On that edge:
//    vec_q <= enc_code, pend[enc_code] <= 0, ien <= 0.
//   REQ  -> IDLE with no ack if |req_vec=0 or ien_q=0 (request withdrawn).
//    pend_q and vec_q are unchanged.
//  ack while in IDLE is ignored: no pend, ien or vec_q change.
//  enc_code is trusted to be the encoder's output for the current req_vec.
//   enc_code is only used when ack is accepted, so its X value for
//   req_vec=0 is never consumed.
//  rst_n low mid-handshake: immediate return to the reset state. Pending
//   events are discarded.
// TESTING
//  T1 reset: rst_n=0, irq_in=8'hFF -> all outputs 0.
//     After release with ien=0 -> pend_q=8'hFF 3 clocks later, int_req stays 0.
//  T2 ien_set, irq_in[5] pulse -> int_req=1 one clock after pend_q[5].
//     ack with enc_code=3'd5 -> vec_q=5, pend_q[5]=0, ien_q=0, int_req=0.
//  T3 irq 2 and 6 both pending, ien=1 -> ack code 6 clears bit 6 only.
//     Then ien_set -> int_req again, ack code 2 -> pend_q=0.
//  T4 pending 8'h08 with mask_wdata=8'h08 -> req_vec=0, int_req withdrawn,
//     pend_q keeps 8'h08. Unmask -> int_req returns.
//  T5 new rising edge on irq_in[3] lands on the same edge as ack code 3
//     (EDGE=1) -> pend_q[3]=1 afterwards.
//  T6 ack in IDLE, ien_set+ien_clr together, and rst_n pulsed while int_req=1
//     -> no change, ien_q=0, full reset respectively.

Source files
------------

// File: rtl/intr_req_ctrl.sv
// Interrupt request front end: synchronises and latches 8 request lines, masks them for the
// downstream priority encoder, and runs the IEN-gated CPU request/acknowledge handshake.
module intr_req_ctrl #(
   parameter int N      = 8,
   parameter int CODE_W = 3,
   parameter bit EDGE   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N-1:0]      irq_in,
   input  logic              mask_we,
   input  logic [N-1:0]      mask_wdata,
   input  logic              ien_set,
   input  logic              ien_clr,
   input  logic              ack,
   input  logic [CODE_W-1:0] enc_code,
   output logic [N-1:0]      req_vec,
   output logic              int_req,
   output logic [CODE_W-1:0] vec_q,
   output logic [N-1:0]      pend_q,
   output logic [N-1:0]      mask_q,
   output logic              ien_q
);

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t            state_q;
   logic              int_req_q;
   logic [N-1:0]      s1_q, s2_q, s3_q;
   logic [N-1:0]      set_vec, clr_vec, pend_d;
   logic              accept;
   logic              ien_d;

   assign req_vec = pend_q & ~mask_q;
   assign int_req = int_req_q;
   assign accept  = (state_q == REQ) && ack;
   assign set_vec = EDGE ? (s2_q & ~s3_q) : s2_q;

   // The clear is applied before the set so a fresh event on the retired bit survives.
   always_comb begin
      clr_vec = '0;
      if (accept) clr_vec = {{(N-1){1'b0}}, 1'b1} << enc_code;
      pend_d = (pend_q & ~clr_vec) | set_vec;
   end

   always_comb begin
      ien_d = ien_q;
      if (accept || ien_clr) ien_d = 1'b0;
      else if (ien_set)      ien_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= '0;
         s2_q   <= '0;
         s3_q   <= '0;
         pend_q <= '0;
         mask_q <= '0;
         ien_q  <= 1'b0;
      end else begin
         s1_q   <= irq_in;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         pend_q <= pend_d;
         ien_q  <= ien_d;
         if (mask_we) mask_q <= mask_wdata;
      end
   end

   // Request FSM; int_req is registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         int_req_q <= 1'b0;
         vec_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ien_q && (|req_vec)) begin
                  state_q   <= REQ;
                  int_req_q <= 1'b1;
               end
            end
            REQ: begin
               if (ack) begin
                  state_q   <= IDLE;
                  int_req_q <= 1'b0;
                  vec_q     <= enc_code;
               end else if (!(|req_vec) || !ien_q) begin
                  state_q   <= IDLE;
                  int_req_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               int_req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_intr_req_ctrl.sv
// Directed bench for intr_req_ctrl: reset, request/ack handshake, masking, set-vs-clear race,
// idle ack, IEN priority and mid-handshake reset.
module tb_intr_req_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] irq_in;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic       ien_set;
   logic       ien_clr;
   logic       ack;
   logic [2:0] enc_code;
   logic [7:0] req_vec;
   logic       int_req;
   logic [2:0] vec_q;
   logic [7:0] pend_q;
   logic [7:0] mask_q;
   logic       ien_q;

   int n_checks = 0;
   int n_fail   = 0;

   intr_req_ctrl #(.N(8), .CODE_W(3), .EDGE(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq_in     (irq_in),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .ien_set    (ien_set),
      .ien_clr    (ien_clr),
      .ack        (ack),
      .enc_code   (enc_code),
      .req_vec    (req_vec),
      .int_req    (int_req),
      .vec_q      (vec_q),
      .pend_q     (pend_q),
      .mask_q     (mask_q),
      .ien_q      (ien_q)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
      ien_set = 1'b0; ien_clr = 1'b0; ack = 1'b0; enc_code = '0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic pulse_ien_set();
      ien_set = 1'b1; tick(); ien_set = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; irq_in = 8'hFF; mask_we = 1'b0; mask_wdata = '0;
      ien_set = 1'b0; ien_clr = 1'b0; ack = 1'b0; enc_code = '0;
      tick(); tick();
      n_checks++;
      if ({pend_q, mask_q, req_vec, vec_q, ien_q, int_req} !== 29'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got pend=%h mask=%h req=%h vec=%0d ien=%b int=%b, want all 0",
                  pend_q, mask_q, req_vec, vec_q, ien_q, int_req);
      end
      rst_n = 1'b1;
      tick(); tick();
      n_checks++;
      if (pend_q !== 8'h00) begin n_fail++; $display("FAIL reset_pend_early: got %h want 00", pend_q); end
      tick();
      n_checks++;
      if (pend_q !== 8'hFF) begin n_fail++; $display("FAIL reset_pend_3clk: got %h want ff", pend_q); end
      tick();
      n_checks++;
      if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_no_int_ien0: got %b want 0", int_req); end
      irq_in = '0;
   endtask

   task automatic test_single_irq();
      do_reset();
      pulse_ien_set();
      n_checks++;
      if (ien_q !== 1'b1) begin n_fail++; $display("FAIL t2_ien_set: got %b want 1", ien_q); end
      irq_in = 8'h20; tick(); irq_in = '0;
      tick(); tick();
      n_checks++;
      if (pend_q !== 8'h20 || int_req !== 1'b0) begin
         n_fail++; $display("FAIL t2_pend: got pend=%h int=%b want 20/0", pend_q, int_req);
      end
      tick();
      n_checks++;
      if (int_req !== 1'b1) begin n_fail++; $display("FAIL t2_int_req: got %b want 1", int_req); end
      ack = 1'b1; enc_code = 3'd5; tick(); ack = 1'b0;
      n_checks++;
      if (vec_q !== 3'd5 || pend_q !== 8'h00 || ien_q !== 1'b0 || int_req !== 1'b0) begin
         n_fail++;
         $display("FAIL t2_ack: got vec=%0d pend=%h ien=%b int=%b want 5/00/0/0", vec_q, pend_q, ien_q, int_req);
      end
   endtask

   task automatic test_two_sources();
      do_reset();
      pulse_ien_set();
      irq_in = 8'h44; tick(); irq_in = '0;
      tick(); tick(); tick();
      n_checks++;
      if (pend_q !== 8'h44 || int_req !== 1'b1) begin
         n_fail++; $display("FAIL t3_both_pend: got pend=%h int=%b want 44/1", pend_q, int_req);
      end
      ack = 1'b1; enc_code = 3'd6; tick(); ack = 1'b0;
      n_checks++;
      if (pend_q !== 8'h04 || vec_q !== 3'd6 || ien_q !== 1'b0 || int_req !== 1'b0) begin
         n_fail++;
         $display("FAIL t3_ack6: got pend=%h vec=%0d ien=%b int=%b want 04/6/0/0", pend_q, vec_q, ien_q, int_req);
      end
      pulse_ien_set();
      tick();
      n_checks++;
      if (int_req !== 1'b1) begin n_fail++; $display("FAIL t3_rereq: got %b want 1", int_req); end
      ack = 1'b1; enc_code = 3'd2; tick(); ack = 1'b0;
      n_checks++;
      if (pend_q !== 8'h00 || vec_q !== 3'd2) begin
         n_fail++; $display("FAIL t3_ack2: got pend=%h vec=%0d want 00/2", pend_q, vec_q);
      end
   endtask

   task automatic test_mask();
      do_reset();
      pulse_ien_set();
      irq_in = 8'h08; tick(); irq_in = '0;
      tick(); tick(); tick();
      mask_we = 1'b1; mask_wdata = 8'h08; tick(); mask_we = 1'b0;
      n_checks++;
      if (mask_q !== 8'h08 || req_vec !== 8'h00) begin
         n_fail++; $display("FAIL t4_mask: got mask=%h req=%h want 08/00", mask_q, req_vec);
      end
      tick();
      n_checks++;
      if (int_req !== 1'b0 || pend_q !== 8'h08) begin
         n_fail++; $display("FAIL t4_withdraw: got int=%b pend=%h want 0/08", int_req, pend_q);
      end
      mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
      n_checks++;
      if (req_vec !== 8'h08) begin n_fail++; $display("FAIL t4_unmask_req: got %h want 08", req_vec); end
      tick();
      n_checks++;
      if (int_req !== 1'b1) begin n_fail++; $display("FAIL t4_int_back: got %b want 1", int_req); end
   endtask

   task automatic test_set_clear_race();
      do_reset();
      pulse_ien_set();
      irq_in = 8'h08; tick();
      irq_in = 8'h00; tick();
      irq_in = 8'h08; tick();
      irq_in = 8'h00;
      n_checks++;
      if (pend_q !== 8'h08) begin n_fail++; $display("FAIL t5_pend_first: got %h want 08", pend_q); end
      tick();
      ack = 1'b1; enc_code = 3'd3; tick(); ack = 1'b0;
      n_checks++;
      if (pend_q !== 8'h08 || vec_q !== 3'd3 || int_req !== 1'b0) begin
         n_fail++; $display("FAIL t5_set_wins: got pend=%h vec=%0d int=%b want 08/3/0", pend_q, vec_q, int_req);
      end
   endtask

   task automatic test_misc();
      do_reset();
      irq_in = 8'h01; tick(); irq_in = '0;
      tick(); tick();
      ack = 1'b1; enc_code = 3'd0; tick(); ack = 1'b0;
      n_checks++;
      if (pend_q !== 8'h01 || vec_q !== 3'd0 || ien_q !== 1'b0 || int_req !== 1'b0) begin
         n_fail++;
         $display("FAIL t6_idle_ack: got pend=%h vec=%0d ien=%b int=%b want 01/0/0/0", pend_q, vec_q, ien_q, int_req);
      end
      ien_set = 1'b1; ien_clr = 1'b1; tick(); ien_set = 1'b0; ien_clr = 1'b0;
      n_checks++;
      if (ien_q !== 1'b0) begin n_fail++; $display("FAIL t6_clr_beats_set: got %b want 0", ien_q); end
      pulse_ien_set();
      tick();
      n_checks++;
      if (int_req !== 1'b1) begin n_fail++; $display("FAIL t6_int_before_rst: got %b want 1", int_req); end
      mask_we = 1'b1; mask_wdata = 8'hA5; tick(); mask_we = 1'b0;
      rst_n = 1'b0; #1;
      n_checks++;
      if ({pend_q, mask_q, req_vec, vec_q, ien_q, int_req} !== 29'd0) begin
         n_fail++;
         $display("FAIL t6_mid_reset: got pend=%h mask=%h req=%h vec=%0d ien=%b int=%b want all 0",
                  pend_q, mask_q, req_vec, vec_q, ien_q, int_req);
      end
      tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      n_checks++;
      if (pend_q !== 8'h00 || int_req !== 1'b0) begin
         n_fail++; $display("FAIL t6_events_discarded: got pend=%h int=%b want 00/0", pend_q, int_req);
      end
   endtask

   initial begin
      test_reset();
      test_single_irq();
      test_two_sources();
      test_mask();
      test_set_clear_race();
      test_misc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
